// File: rtl/aes_inv_key_feeder.sv
// Round-key source for the AES inverse cipher: expands one cipher key into a
// word store, then presents round keys from round Nr down to round 0.
module aes_inv_key_feeder #(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [32*Nk-1:0]  key_in,
   input  logic              key_load,
   input  logic              key_restart,
   input  logic              key_ack,
   output logic [127:0]      k_sch,
   output logic [4:0]        key_avail,
   output logic              busy,
   output logic              sched_ok
);

   localparam int NW  = 4 * (Nr + 1);
   localparam int WIW = $clog2(NW);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      PLAY   = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t          r_state;
   logic [31:0]     r_w [NW];
   logic [WIW-1:0]  r_wi;
   logic [3:0]      r_mod;     // wi mod Nk, tracked incrementally to avoid a divider
   logic [3:0]      r_rci;     // wi / Nk, valid when r_mod is zero
   logic [4:0]      r_step;

   logic [31:0]     w_prev;
   logic [31:0]     w_back;
   logic [31:0]     w_t;
   logic [31:0]     w_new;
   logic [4:0]      w_sel_step;
   logic [WIW-1:0]  w_base;
   logic [127:0]    w_rd;

   assign w_prev = r_w[r_wi - WIW'(1)];
   assign w_back = r_w[r_wi - WIW'(Nk)];
   assign w_new  = w_back ^ w_t;

   // Key-schedule recurrence for the word at r_wi.
   always_comb begin
      w_t = w_prev;
      if (r_mod == 4'd0) begin
         w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(r_rci), 24'h000000};
      end else if ((Nk == 8) && (r_mod == 4'd4)) begin
         w_t = sub_word(w_prev);
      end else begin
         w_t = w_prev;
      end
   end

   // Step to present next: step 0 on schedule entry or replay, otherwise the following step.
   always_comb begin
      w_sel_step = r_step + 5'd1;
      if ((r_state == EXPAND) || key_restart) begin
         w_sel_step = 5'd0;
      end else begin
         w_sel_step = r_step + 5'd1;
      end
      w_base = WIW'(4 * Nr) - WIW'({w_sel_step, 2'b00});
      w_rd   = {r_w[w_base], r_w[w_base + WIW'(1)], r_w[w_base + WIW'(2)], r_w[w_base + WIW'(3)]};
   end

   // Control FSM, word store and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_wi      <= '0;
         r_mod     <= 4'd0;
         r_rci     <= 4'd0;
         r_step    <= 5'd0;
         k_sch     <= 128'd0;
         key_avail <= 5'h1F;
         busy      <= 1'b0;
         sched_ok  <= 1'b0;
      end else if (key_load) begin
         for (int i = 0; i < Nk; i++) begin
            r_w[i] <= key_in[32*(Nk-i)-1 -: 32];
         end
         r_wi      <= WIW'(Nk);
         r_mod     <= 4'd0;
         r_rci     <= 4'd1;
         r_state   <= EXPAND;
         key_avail <= 5'h1F;
         busy      <= 1'b1;
         sched_ok  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= IDLE;
            end
            EXPAND: begin
               if (r_wi == WIW'(NW)) begin
                  k_sch     <= w_rd;
                  key_avail <= 5'd0;
                  r_step    <= 5'd0;
                  r_state   <= PLAY;
                  busy      <= 1'b0;
                  sched_ok  <= 1'b1;
               end else begin
                  r_w[r_wi] <= w_new;
                  r_wi      <= r_wi + WIW'(1);
                  r_mod     <= (r_mod == 4'(Nk - 1)) ? 4'd0 : r_mod + 4'd1;
                  if (r_mod == 4'd0) begin
                     r_rci <= r_rci + 4'd1;
                  end
               end
            end
            PLAY: begin
               if (key_restart) begin
                  k_sch     <= w_rd;
                  key_avail <= 5'd0;
                  r_step    <= 5'd0;
               end else if (key_ack) begin
                  if (r_step == 5'(Nr)) begin
                     key_avail <= 5'(Nr + 1);
                     r_state   <= DONE;
                  end else begin
                     k_sch     <= w_rd;
                     key_avail <= r_step + 5'd1;
                     r_step    <= r_step + 5'd1;
                  end
               end
            end
            DONE: begin
               if (key_restart) begin
                  k_sch     <= w_rd;
                  key_avail <= 5'd0;
                  r_step    <= 5'd0;
                  r_state   <= PLAY;
               end
            end
            default: begin
               r_state   <= IDLE;
               key_avail <= 5'h1F;
               busy      <= 1'b0;
               sched_ok  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_key_feeder.sv
// Bench for aes_inv_key_feeder: three key sizes driven in lockstep, playback
// checked through a table-driven scoreboard plus abort/reset sequences.
module tb_aes_inv_key_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, key_load, key_restart, key_ack;
   logic [127:0]  key4;
   logic [191:0]  key6;
   logic [255:0]  key8;
   logic [127:0]  k4, k6, k8;
   logic [4:0]    a4, a6, a8;
   logic          b4, b6, b8, o4, o6, o8;

   aes_inv_key_feeder #(.Nk(4)) dut4 (.clk(clk), .rst(rst), .key_in(key4), .key_load(key_load),
      .key_restart(key_restart), .key_ack(key_ack), .k_sch(k4), .key_avail(a4), .busy(b4), .sched_ok(o4));
   aes_inv_key_feeder #(.Nk(6)) dut6 (.clk(clk), .rst(rst), .key_in(key6), .key_load(key_load),
      .key_restart(key_restart), .key_ack(key_ack), .k_sch(k6), .key_avail(a6), .busy(b6), .sched_ok(o6));
   aes_inv_key_feeder #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .key_in(key8), .key_load(key_load),
      .key_restart(key_restart), .key_ack(key_ack), .k_sch(k8), .key_avail(a8), .busy(b8), .sched_ok(o8));

   typedef struct {
      logic [4:0]   avail;
      logic [127:0] key;
      logic         ck_key;
   } exp_t;

   typedef struct {
      logic ack;
      logic restart;
      exp_t e;
   } vec_t;

   localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] R2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   vec_t vtab[16];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_play(output int n);
      n = -1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (a4 == 5'd0) begin
            n = c;
            break;
         end
      end
   endtask

   initial begin
      int   c4, c6, c8, n;
      exp_t e;

      vtab[0]  = '{1'b1, 1'b0, '{5'd1,  R9,  1'b1}};
      vtab[1]  = '{1'b1, 1'b0, '{5'd2,  R9,  1'b0}};
      vtab[2]  = '{1'b1, 1'b0, '{5'd3,  R9,  1'b0}};
      vtab[3]  = '{1'b1, 1'b0, '{5'd4,  R9,  1'b0}};
      vtab[4]  = '{1'b1, 1'b0, '{5'd5,  R9,  1'b0}};
      vtab[5]  = '{1'b1, 1'b0, '{5'd6,  R9,  1'b0}};
      vtab[6]  = '{1'b1, 1'b0, '{5'd7,  R9,  1'b0}};
      vtab[7]  = '{1'b1, 1'b0, '{5'd8,  R2,  1'b1}};
      vtab[8]  = '{1'b1, 1'b0, '{5'd9,  R1,  1'b1}};
      vtab[9]  = '{1'b1, 1'b0, '{5'd10, R0,  1'b1}};
      vtab[10] = '{1'b1, 1'b0, '{5'd11, R0,  1'b1}};
      vtab[11] = '{1'b1, 1'b0, '{5'd11, R0,  1'b1}};
      vtab[12] = '{1'b0, 1'b1, '{5'd0,  R10, 1'b1}};
      vtab[13] = '{1'b1, 1'b0, '{5'd1,  R9,  1'b1}};
      vtab[14] = '{1'b1, 1'b1, '{5'd0,  R10, 1'b1}};
      vtab[15] = '{1'b0, 1'b0, '{5'd0,  R10, 1'b1}};

      rst = 1'b1; key_load = 1'b0; key_restart = 1'b0; key_ack = 1'b0;
      key4 = R0;
      key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
      key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      tick();
      tick();
      chk("rst_ksch", k4, 128'd0);
      chk("rst_avail", 128'(a4), 128'h1F);
      chk("rst_busy", 128'(b4), 128'd0);
      chk("rst_ok", 128'(o4), 128'd0);
      rst = 1'b0;

      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      chk("idle_ack", 128'(a4), 128'h1F);

      // Load all three key sizes and time each PLAY entry
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      chk("load_busy", 128'(b4), 128'd1);
      chk("load_avail", 128'(a4), 128'h1F);
      c4 = -1; c6 = -1; c8 = -1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (a4 == 5'd0 && c4 < 0) c4 = c;
         if (a6 == 5'd0 && c6 < 0) c6 = c;
         if (a8 == 5'd0 && c8 < 0) c8 = c;
      end
      chk("lat4", 128'(c4), 128'd41);
      chk("lat6", 128'(c6), 128'd47);
      chk("lat8", 128'(c8), 128'd53);
      chk("nk4_r10", k4, R10);
      chk("nk6_r12", k6, 128'he98ba06f448c773c8ecc720401002202);
      chk("nk8_r14", k8, 128'hfe4890d1e6188d0b046df344706c631e);
      chk("play_busy", 128'(b4), 128'd0);
      chk("play_ok", 128'(o4), 128'd1);

      key_ack = 1'b1;
      repeat (13) tick();
      key_ack = 1'b0;
      chk("nk8_s13_avail", 128'(a8), 128'd13);
      chk("nk8_s13", k8, 128'h1f352c073b6108d72d9810a30914dff4);
      chk("nk6_s12", k6, 128'h8e73b0f7da0e6452c810f32b809079e5);
      chk("nk4_done", 128'(a4), 128'd11);
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      chk("nk8_s14_avail", 128'(a8), 128'd14);
      chk("nk8_s14", k8, 128'h603deb1015ca71be2b73aef0857d7781);
      chk("nk6_done", 128'(a6), 128'd13);

      key_restart = 1'b1;
      tick();
      key_restart = 1'b0;
      chk("replay_avail", 128'(a4), 128'd0);
      chk("replay_key", k4, R10);
      chk("replay_busy", 128'(b4), 128'd0);

      for (int i = 0; i < 16; i++) begin
         key_ack = vtab[i].ack;
         key_restart = vtab[i].restart;
         sbq.push_back(vtab[i].e);
         tick();
         key_ack = 1'b0;
         key_restart = 1'b0;
         e = sbq.pop_front();
         chk($sformatf("tab%0d_avail", i), 128'(a4), 128'(e.avail));
         if (e.ck_key) chk($sformatf("tab%0d_key", i), k4, e.key);
         chk($sformatf("tab%0d_busy", i), 128'(b4), 128'd0);
         chk($sformatf("tab%0d_ok", i), 128'(o4), 128'd1);
      end

      // Abort playback at step 5 with a fresh load
      key_ack = 1'b1;
      repeat (5) tick();
      key_ack = 1'b0;
      chk("abort_step", 128'(a4), 128'd5);
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      chk("abort_ok", 128'(o4), 128'd0);
      chk("abort_busy", 128'(b4), 128'd1);
      chk("abort_avail", 128'(a4), 128'h1F);
      wait_play(n);
      chk("abort_lat", 128'(n), 128'd41);
      chk("abort_key", k4, R10);

      // key_load wins over key_restart
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      key_load = 1'b1;
      key_restart = 1'b1;
      tick();
      key_load = 1'b0;
      key_restart = 1'b0;
      chk("prio_busy", 128'(b4), 128'd1);
      chk("prio_avail", 128'(a4), 128'h1F);
      wait_play(n);
      chk("prio_lat", 128'(n), 128'd41);

      // Reset in the middle of expansion
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ksch", k4, 128'd0);
      chk("mid_rst_avail", 128'(a4), 128'h1F);
      chk("mid_rst_busy", 128'(b4), 128'd0);
      chk("mid_rst_ok", 128'(o4), 128'd0);
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      chk("post_rst_idle", 128'(a4), 128'h1F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
